// File: rtl/serial_subtractor_32.sv
// Slice-serial subtractor: d = x - y - bin, one SLICE_W-bit slice per clock,
// LSB slice first, with a registered borrow chain and a start/done handshake.
module serial_subtractor_32 #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NSLICE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   x_reg, y_reg;
    logic               borrow;
    logic [IDX_W-1:0]   k;
    logic               accept, last;
    logic [SLICE_W-1:0] r;
    logic               b;
    int                 base;

    // Zero-extended so the extra top bit of the result is the slice borrow-out.
    function automatic logic [SLICE_W:0] slice_sub(input logic [SLICE_W-1:0] a,
                                                   input logic [SLICE_W-1:0] s,
                                                   input logic               c);
        return {1'b0, a} - {1'b0, s} - {{SLICE_W{1'b0}}, c};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        base       = int'(k) * SLICE_W;
        {b, r}     = slice_sub(x_reg[base +: SLICE_W], y_reg[base +: SLICE_W], borrow);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (k == LAST_K) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg  <= '0;
            y_reg  <= '0;
            borrow <= 1'b0;
            k      <= '0;
            done   <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                x_reg  <= x;
                y_reg  <= y;
                borrow <= bin;
                k      <= '0;
            end else if (state == RUN) begin
                d[base +: SLICE_W] <= r;
                borrow             <= b;
                k                  <= last ? '0 : k + IDX_W'(1);
                // Flags reflect the full-width operation, taken from the MSB slice only.
                if (last) begin
                    bout <= b;
                    ovf  <= (x_reg[WIDTH-1] != y_reg[WIDTH-1]) && (r[SLICE_W-1] != x_reg[WIDTH-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Directed bench for serial_subtractor_32: vector table plus handshake,
// back-to-back and asynchronous-reset sequences.
module tb_serial_subtractor_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] x, y;
    logic        bin;
    logic        busy, done, bout, ovf;
    logic [31:0] d;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        bin;
        logic [31:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    serial_subtractor_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Starts one operation and waits (bounded) for done; returns edges from accept to done.
    task automatic run_op(input logic [31:0] xv, input logic [31:0] yv, input logic bv,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        x = xv; y = yv; bin = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_ok = busy;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        if (lat == 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done within 20 edges required done");
        end
    endtask

    int   lat;
    logic bok;
    int   pulses;

    initial begin
        vecs[0] = '{32'h55555555, 32'h2AAAAAAA, 1'b0, 32'h2AAAAAAB, 1'b0, 1'b0};
        vecs[1] = '{32'h55555555, 32'h2AAAAAAA, 1'b1, 32'h2AAAAAAA, 1'b0, 1'b0};
        vecs[2] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[7] = '{32'h00000010, 32'h00000001, 1'b0, 32'h0000000F, 1'b0, 1'b0};
        vecs[8] = '{32'h12345678, 32'h02345678, 1'b0, 32'h10000000, 1'b0, 1'b0};

        rst_n = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_d", d, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_bout", {31'b0, bout}, 32'h0);
        chk("reset_ovf", {31'b0, ovf}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].bin, lat, bok);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_busy", i), {31'b0, bok}, 32'h1);
            chk($sformatf("vec%0d_d", i), d, vecs[i].d);
            chk($sformatf("vec%0d_bout", i), {31'b0, bout}, {31'b0, vecs[i].bout});
            chk($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
            @(posedge clk);
            #1 chk($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'h0);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        x = 32'h55555555; y = 32'h2AAAAAAA; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x = 32'h00000000; y = 32'h00000001; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("hs_busy_e2", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1 chk("hs_busy_e3", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
        chk("hs_done_e4", {31'b0, done}, 32'h1);
        chk("hs_first_d", d, 32'h2AAAAAAB);
        chk("hs_first_bout", {31'b0, bout}, 32'h0);
        x = 32'h00000010; y = 32'h00000001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy_accept", {31'b0, busy}, 32'h1);
        chk("b2b_done_clear", {31'b0, done}, 32'h0);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("b2b_latency", lat, 4);
        chk("b2b_d", d, 32'h0000000F);
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        chk("hs_no_extra_done", pulses, 0);

        // Asynchronous reset while slice 2 is pending.
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bok);
        chk("pre_rst_bout", {31'b0, bout}, 32'h1);
        chk("pre_rst_ovf", {31'b0, ovf}, 32'h1);
        @(negedge clk);
        x = 32'hA5A5A5A5; y = 32'h01010101; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_d", d, 32'h0);
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        chk("rst_mid_done", {31'b0, done}, 32'h0);
        chk("rst_mid_bout", {31'b0, bout}, 32'h0);
        chk("rst_mid_ovf", {31'b0, ovf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        chk("rst_no_done", pulses, 0);
        run_op(32'h12345678, 32'h02345678, 1'b0, lat, bok);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_d", d, 32'h10000000);
        chk("post_rst_bout", {31'b0, bout}, 32'h0);
        chk("post_rst_ovf", {31'b0, ovf}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
